// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, round keys derived on the fly.
// Optional abort input is enabled by defining AES_CTRL_ABORT_EN.
module aes_round_ctrl #(
  parameter int          NR        = 10,
  parameter logic [7:0]  RCON_INIT = 8'h01
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [3:0]   round
`ifdef AES_CTRL_ABORT_EN
  ,
  input  logic         abort
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = int'(b);
    return SBOX[2047 - 8*idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  // Byte (row r, column c) sits at index 4c+r; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]), mix_column(s[63:32]), mix_column(s[31:0])};
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  ctrl_state_e  fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] rk_next;
  logic [127:0] sr_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      round_q <= '0;
      rcon_q  <= RCON_INIT;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    rk_d     = rk_q;
    round_d  = round_q;
    rcon_d   = rcon_q;
    rk_next  = expand_key(rk_q, rcon_q);
    sr_state = shift_rows(sub_bytes(state_q));

    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          fsm_d   = RUN;
          state_d = in_block ^ in_key;
          rk_d    = in_key;
          round_d = 4'd1;
          rcon_d  = RCON_INIT;
        end
      end
      RUN: begin
        rk_d   = rk_next;
        rcon_d = xtime(rcon_q);
        // The final round skips mixColumns and hands the result straight to DONE.
        if (round_q == LAST_ROUND) begin
          state_d = sr_state ^ rk_next;
          round_d = 4'd0;
          fsm_d   = DONE;
        end else begin
          state_d = mix_columns(sr_state) ^ rk_next;
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

`ifdef AES_CTRL_ABORT_EN
    // Abort overrides both round completion and the output handshake.
    if (abort && (fsm_q != IDLE)) begin
      fsm_d   = IDLE;
      state_d = '0;
      rk_d    = '0;
      round_d = '0;
      rcon_d  = RCON_INIT;
    end
`endif
  end

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == RUN);
  assign out_valid = (fsm_q == DONE);
  assign out_block = state_q;
  assign round     = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl using FIPS-197 vectors and an expected-ciphertext queue.
// Abort scenario is exercised when AES_CTRL_ABORT_EN is defined.
module tb_aes_round_ctrl;

   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic         clk;
   logic         rstN;
   logic         inValid;
   logic         inReady;
   logic [127:0] inBlock;
   logic [127:0] inKey;
   logic         outValid;
   logic         outReady;
   logic [127:0] outBlock;
   logic         busy;
   logic [3:0]   round;
`ifdef AES_CTRL_ABORT_EN
   logic         abort;
`endif

   int           checkCount;
   int           errorCount;
   int           cyc;
   int           lastAccept;
   int           hsEdge;
   logic         prevOutValid;
   logic [127:0] expQ[$];

   aes_round_ctrl dut (
      .clk       (clk),
      .rst_n     (rstN),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_block  (inBlock),
      .in_key    (inKey),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_block (outBlock),
      .busy      (busy),
      .round     (round)
`ifdef AES_CTRL_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   // Free-running clock and a cycle counter used to measure latency.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Presents a job and waits for the accept edge; optionally keeps inValid high afterwards.
   task automatic applyStimulus(input logic [127:0] blk, input logic [127:0] key,
                                input logic [127:0] expCt, input bit holdValid);
      bit accepted;
      bit rdy;
      accepted = 1'b0;
      inBlock  = blk;
      inKey    = key;
      inValid  = 1'b1;
      for (int i = 0; i < 60; i++) begin
         rdy = inReady;
         @(posedge clk);
         #1;
         if (rdy) begin
            accepted = 1'b1;
            expQ.push_back(expCt);
            lastAccept = cyc;
            break;
         end
      end
      if (!accepted) checkOutput("acceptTimeout", 0, 1);
      if (!holdValid) inValid = 1'b0;
   endtask

   task automatic waitDrain(input int maxCyc);
      for (int i = 0; i < maxCyc; i++) begin
         if (expQ.size() == 0) break;
         @(posedge clk);
         #1;
      end
      checkOutput("drainTimeout", 128'(expQ.size()), 0);
   endtask

   task automatic waitRound(input logic [3:0] target);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (round == target && busy) begin
            hit = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      checkOutput("roundReached", hit, 1);
   endtask

   // Output side of the scoreboard plus latency and round-index monitoring.
   always @(negedge clk) begin
      if (rstN) begin
         if (outValid && !prevOutValid) checkOutput("latency", 128'(cyc - lastAccept), 10);
         if (busy) checkOutput("roundSeq", round, 128'(cyc - lastAccept + 1));
         if (outValid) checkOutput("roundDone", round, 0);
         if (outValid && outReady) begin
            hsEdge = cyc + 1;
            if (expQ.size() == 0) begin
               checkOutput("unexpectedOut", 1, 0);
            end else begin
               checkOutput("cipherText", outBlock, expQ.pop_front());
            end
         end
      end
      prevOutValid = outValid;
   end

   initial begin
      checkCount   = 0;
      errorCount   = 0;
      cyc          = 0;
      lastAccept   = 0;
      hsEdge       = 0;
      prevOutValid = 1'b0;
      rstN         = 1'b0;
      inValid      = 1'b0;
      inBlock      = '0;
      inKey        = '0;
      outReady     = 1'b0;
`ifdef AES_CTRL_ABORT_EN
      abort        = 1'b0;
`endif

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstInReady", inReady, 1);
      checkOutput("rstOutValid", outValid, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstRound", round, 0);
      checkOutput("rstOutBlock", outBlock, 0);
      rstN = 1'b1;
      @(posedge clk);
      #1;

      // App. B with the consumer always ready: out_valid lasts one cycle
      outReady = 1'b1;
      applyStimulus(B_PT, B_KEY, B_CT, 1'b0);
      checkOutput("busyAfterAccept", busy, 1);
      checkOutput("inReadyInRun", inReady, 0);
      waitDrain(30);
      checkOutput("outValidOneCycle", outValid, 0);
      checkOutput("idleAfterB", inReady, 1);

      // App. C.1 with backpressure: result held stable for 5 cycles
      outReady = 1'b0;
      applyStimulus(C_PT, C_KEY, C_CT, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (outValid) break;
         checkOutput("inReadyWhileRun", inReady, 0);
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 5; i++) begin
         checkOutput("holdValid", outValid, 1);
         checkOutput("holdBlock", outBlock, C_CT);
         checkOutput("holdInReady", inReady, 0);
         @(posedge clk);
         #1;
      end
      outReady = 1'b1;
      waitDrain(10);
      checkOutput("idleAfterC", inReady, 1);

      // Back-to-back jobs with in_valid held high
      applyStimulus(B_PT, B_KEY, B_CT, 1'b1);
      applyStimulus(C_PT, C_KEY, C_CT, 1'b1);
      checkOutput("b2bGap", 128'(lastAccept - hsEdge), 1);
      inValid = 1'b0;
      waitDrain(30);

      // in_valid pulsed during RUN with a different block is ignored
      applyStimulus(B_PT, B_KEY, B_CT, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      inBlock = C_PT;
      inKey   = C_KEY;
      inValid = 1'b1;
      checkOutput("pulseInReady", inReady, 0);
      repeat (2) @(posedge clk);
      #1;
      inValid = 1'b0;
      waitDrain(30);

      // Reset in the middle of a job discards it
      applyStimulus(C_PT, C_KEY, C_CT, 1'b0);
      waitRound(4'd5);
      rstN = 1'b0;
      #1;
      checkOutput("midRstOutValid", outValid, 0);
      checkOutput("midRstRound", round, 0);
      checkOutput("midRstInReady", inReady, 1);
      checkOutput("midRstBusy", busy, 0);
      expQ.delete();
      @(posedge clk);
      #1;
      rstN = 1'b1;
      applyStimulus(B_PT, B_KEY, B_CT, 1'b0);
      waitDrain(30);

`ifdef AES_CTRL_ABORT_EN
      // Abort at round 3 returns to IDLE with no ciphertext delivered
      applyStimulus(B_PT, B_KEY, B_CT, 1'b0);
      waitRound(4'd3);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      expQ.delete();
      checkOutput("abortInReady", inReady, 1);
      checkOutput("abortRound", round, 0);
      checkOutput("abortOutValid", outValid, 0);
      checkOutput("abortState", outBlock, 0);
      repeat (12) @(posedge clk);
      #1;
      checkOutput("abortNoOutput", outValid, 0);
      applyStimulus(C_PT, C_KEY, C_CT, 1'b0);
      waitDrain(30);
`endif

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES-128 encryption controller that runs one round per clock.
- Accepts a plaintext/key pair over a valid/ready handshake and derives round keys on the fly.
- Sequences the existing sub-bytes, shift-rows and mixColumns datapath for rounds 1..10, and omits mixColumns in round 10.
- Sits between the SPI front-end and the ciphertext output register, and is the only user of the round datapath.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported.
- RCON_INIT, 8'h01, first round constant.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_block and in_key are valid.
- in_ready  output  1  controller can accept a new job.
- in_block  input  128  plaintext; byte 0 is in [127:120]; column c is in [127-32c -: 32].
- in_key  input  128  cipher key, same byte order as in_block.
- out_valid  output  1  out_block holds the finished ciphertext.
- out_ready  input  1  downstream consumer accepts out_block.
- out_block  output  128  ciphertext, same byte order.
- busy  output  1  high while in RUN.
- round  output  4  current round index (0..10).
- abort  input  1  present only with AES_CTRL_ABORT_EN.

Behaviour:
- Reset (asynchronous, rst_n low) sets every output and register to a known value:
  - FSM to IDLE.
  - state_reg, rk_reg and out_block to 0.
  - round to 0, rcon_reg to RCON_INIT.
  - in_ready=1, out_valid=0, busy=0.
- FSM states:
  - IDLE: in_ready=1.
  - RUN: busy=1, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE -> RUN on accept (in_valid & in_ready) at edge N. At that edge:
  - state_reg <= in_block ^ in_key (round 0).
  - rk_reg <= in_key; round <= 1; rcon_reg <= RCON_INIT.
- RUN, each edge:
  - rk_next = key expansion of rk_reg using rcon_reg:
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
    - w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - state_reg <= MC(SR(SB(state_reg))) ^ rk_next when round < NR; SR(SB(state_reg)) ^ rk_next when round == NR.
  - rk_reg <= rk_next; rcon_reg <= xtime(rcon_reg) (sequence 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36); round <= round + 1.
  - When round == NR: go to DONE and set round to 0.
- Latency: rounds execute at edges N+1..N+10; out_valid rises after edge N+10 (10 cycles after acceptance).
- out_block is driven directly from state_reg and stays stable while out_valid=1 and out_ready=0 (no data change, no drop).
- DONE -> IDLE on out_valid & out_ready. A new job is not accepted in the same cycle; the earliest next accept is the following cycle.
- in_valid while not IDLE is ignored. The controller does not latch inputs except at accept.
- round wraps 10 -> 0 on the RUN -> DONE edge and never exceeds 10.
- Reset asserted mid-RUN or in DONE discards the job; outputs return to reset values asynchronously.
- SubWord/SB reuse the codebase S-box. MC is the existing mixColumns block, combinational, with no added pipeline stage.

Optional Feature:
- Macro: AES_CTRL_ABORT_EN.
- Defined:
  - abort port exists.
  - abort=1 at an edge while in RUN or DONE forces IDLE, clears state_reg, rk_reg and round to 0, and deasserts out_valid; no ciphertext is delivered.
  - abort in IDLE is ignored.
  - abort has priority over completion and over the out handshake in the same cycle.
- Undefined: no abort port; behaviour is exactly as above.

Test Plan:
- FIPS-197 App. B: in_block=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> out_block=3925841d02dc09fbdc118597196a0b32, out_valid high exactly 10 cycles after accept, for 1 cycle.
- App. C.1: in_block=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f, out_ready=0 for 5 cycles after done -> out_block=69c4e0d86a7b0430d8cdb78070b4c55a held stable for 5 cycles; in_ready=0 throughout.
- Back-to-back: in_valid held high with two jobs, out_ready=1 -> second accept occurs 1 cycle after the first output handshake; both ciphertexts correct; round sequence 1..10 then 0.
- in_valid pulsed during RUN with a different block -> ignored; first result unchanged.
- rst_n low at round 5 -> out_valid=0, round=0, in_ready=1 immediately; the next job (App. B vectors) completes correctly.
- With AES_CTRL_ABORT_EN: abort at round 3 -> IDLE next edge, no out_valid; the following App. C.1 job is correct.
